// File: rtl/ddr3_amm_slave_model_pkg.sv
// Shared definitions for the DDR3 Avalon-MM slave model: FSM encoding and
// parameter legality helpers.
package ddr3_amm_slave_model_pkg;

    typedef enum logic [1:0] {
        CAL      = 2'd0,
        IDLE     = 2'd1,
        WR_BURST = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // The read path needs the RAM register plus at least one output stage.
    function automatic bit rd_latency_ok(input int lat);
        return lat >= 2;
    endfunction

    function automatic bit burst_width_ok(input int bw);
        return bw >= 1 && bw <= 16;
    endfunction

endpackage

// File: rtl/ddr3_amm_slave_model_ram.sv
// Simple dual-port RAM: byte-enabled write port, one-cycle registered read port
// that holds its output when no read is issued.
module ddr3_amm_slave_model_ram #(
    parameter int AW = 10,
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   be,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ddr3_amm_slave_model.sv
// Avalon-MM burst responder standing in for the DDR3 EMIF user port, backed by
// on-chip RAM with a fixed read latency and a calibration delay after reset.
module ddr3_amm_slave_model
    import ddr3_amm_slave_model_pkg::*;
#(
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7,
    parameter int MEM_AW      = 10,
    parameter int RD_LATENCY  = 4,
    parameter int CAL_CYCLES  = 64
) (
    input  logic                    ddr_clk,
    input  logic                    app_rst,
    input  logic                    i_stall,
    output logic                    local_cal_success,
    output logic                    amm_ready,
    input  logic                    amm_read,
    input  logic                    amm_write,
    input  logic [ADDR_WIDTH-1:0]   amm_address,
    input  logic [BURST_WIDTH-1:0]  amm_burstcount,
    input  logic [DATA_WIDTH-1:0]   amm_writedata,
    input  logic [DATA_WIDTH/8-1:0] amm_byteenable,
    output logic [DATA_WIDTH-1:0]   amm_readdata,
    output logic                    amm_readdatavalid,
    output logic                    o_err
);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("RD_LATENCY must be >= 2");
    end
    if (!burst_width_ok(BURST_WIDTH)) begin : g_bad_burst
        $error("BURST_WIDTH out of range");
    end

    localparam int CAL_CW = $clog2(CAL_CYCLES + 1);

    state_t                  state, next_state;
    logic [CAL_CW-1:0]       cal_cnt;
    logic [MEM_AW-1:0]       wr_addr, rd_addr, cmd_addr;
    logic [BURST_WIDTH-1:0]  wr_left, iss_left, ret_left, bc_eff;
    logic                    bc_zero, wr_acc, rd_acc;
    logic                    ram_we, ram_re;
    logic [MEM_AW-1:0]       ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [RD_LATENCY-1:0]   vld_pipe;
    logic [RD_LATENCY-1:1][DATA_WIDTH-1:0] dpipe;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^amm_address[ADDR_WIDTH-1:MEM_AW];
    assign cmd_addr       = amm_address[MEM_AW-1:0];
    assign bc_zero        = (amm_burstcount == '0);
    assign bc_eff         = bc_zero ? BURST_WIDTH'(1) : amm_burstcount;

    // amm_ready is only ever high in IDLE/WR_BURST, so it qualifies acceptance alone.
    assign wr_acc = amm_ready && amm_write;
    assign rd_acc = amm_ready && amm_read && !amm_write && (state == IDLE);

    assign amm_readdatavalid = vld_pipe[RD_LATENCY-1];
    assign amm_readdata      = dpipe[RD_LATENCY-1];

    always_comb begin
        next_state = state;
        ram_we     = wr_acc;
        ram_waddr  = (state == WR_BURST) ? wr_addr : cmd_addr;
        // Beat 0 is issued in the accept cycle so the first return lands at RD_LATENCY.
        ram_re     = rd_acc || ((state == RD_BURST) && (iss_left != '0));
        ram_raddr  = (state == RD_BURST) ? rd_addr : cmd_addr;
        case (state)
            CAL:      if (cal_cnt == CAL_CW'(CAL_CYCLES - 1)) next_state = IDLE;
            IDLE: begin
                if (wr_acc) begin
                    if (bc_eff != BURST_WIDTH'(1)) next_state = WR_BURST;
                end else if (rd_acc) begin
                    next_state = RD_BURST;
                end
            end
            WR_BURST: if (wr_acc && wr_left == BURST_WIDTH'(1)) next_state = IDLE;
            RD_BURST: if (amm_readdatavalid && ret_left == BURST_WIDTH'(1)) next_state = IDLE;
            default:  next_state = CAL;
        endcase
    end

    always_ff @(posedge ddr_clk) begin
        if (app_rst) begin
            state             <= CAL;
            cal_cnt           <= '0;
            local_cal_success <= 1'b0;
            amm_ready         <= 1'b0;
            o_err             <= 1'b0;
            wr_addr           <= '0;
            rd_addr           <= '0;
            wr_left           <= '0;
            iss_left          <= '0;
            ret_left          <= '0;
            vld_pipe          <= '0;
            dpipe             <= '0;
        end else begin
            state             <= next_state;
            amm_ready         <= (next_state == IDLE || next_state == WR_BURST) && !i_stall;
            local_cal_success <= local_cal_success || (next_state != CAL);
            if (state == CAL) cal_cnt <= cal_cnt + CAL_CW'(1);

            if (state == IDLE && wr_acc) begin
                wr_addr <= cmd_addr + MEM_AW'(1);
                wr_left <= bc_eff - BURST_WIDTH'(1);
            end else if (state == WR_BURST && wr_acc) begin
                wr_addr <= wr_addr + MEM_AW'(1);
                wr_left <= wr_left - BURST_WIDTH'(1);
            end

            if (rd_acc) begin
                rd_addr  <= cmd_addr + MEM_AW'(1);
                iss_left <= bc_eff - BURST_WIDTH'(1);
                ret_left <= bc_eff;
            end else if (state == RD_BURST) begin
                if (iss_left != '0) begin
                    rd_addr  <= rd_addr + MEM_AW'(1);
                    iss_left <= iss_left - BURST_WIDTH'(1);
                end
                if (amm_readdatavalid) ret_left <= ret_left - BURST_WIDTH'(1);
            end

            if ((state == IDLE && amm_ready && amm_read && amm_write) ||
                (state == WR_BURST && amm_read) ||
                (state == IDLE && (wr_acc || rd_acc) && bc_zero))
                o_err <= 1'b1;

            vld_pipe <= {vld_pipe[RD_LATENCY-2:0], ram_re};
            // Stages only load on valid so the output holds the last beat.
            for (int i = RD_LATENCY - 1; i >= 2; i--) begin
                if (vld_pipe[i-1]) dpipe[i] <= dpipe[i-1];
            end
            if (vld_pipe[0]) dpipe[1] <= ram_rdata;
        end
    end

    ddr3_amm_slave_model_ram #(
        .AW (MEM_AW),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk   (ddr_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (amm_writedata),
        .be    (amm_byteenable),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ddr3_amm_slave_model.sv
// Scoreboard bench for ddr3_amm_slave_model: a bench-side RAM model feeds an
// expected-read queue that is popped as readdatavalid beats arrive.
module tb_ddr3_amm_slave_model;

    localparam int AW = 27, DW = 512, BW = 7, MAW = 10, LAT = 4, CALC = 64;
    localparam int DEPTH = 1 << MAW;
    localparam logic [DW-1:0] POISON = {16{32'hDEAD_BEEF}};

    logic            ddr_clk = 1'b0;
    logic            app_rst = 1'b1;
    logic            i_stall = 1'b0;
    logic            local_cal_success, amm_ready, amm_readdatavalid, o_err;
    logic            amm_read = 1'b0, amm_write = 1'b0;
    logic [AW-1:0]   amm_address = '0;
    logic [BW-1:0]   amm_burstcount = '0;
    logic [DW-1:0]   amm_writedata = '0;
    logic [DW/8-1:0] amm_byteenable = '0;
    logic [DW-1:0]   amm_readdata;

    logic [DW-1:0]   model [DEPTH];
    logic [DW-1:0]   exp_q [$];
    int              t_q [$];
    int              n_pass = 0, n_total = 0;

    always #5 ddr_clk = ~ddr_clk;

    ddr3_amm_slave_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
        .MEM_AW(MAW), .RD_LATENCY(LAT), .CAL_CYCLES(CALC)
    ) dut (
        .ddr_clk(ddr_clk), .app_rst(app_rst), .i_stall(i_stall),
        .local_cal_success(local_cal_success), .amm_ready(amm_ready),
        .amm_read(amm_read), .amm_write(amm_write), .amm_address(amm_address),
        .amm_burstcount(amm_burstcount), .amm_writedata(amm_writedata),
        .amm_byteenable(amm_byteenable), .amm_readdata(amm_readdata),
        .amm_readdatavalid(amm_readdatavalid), .o_err(o_err)
    );

    function automatic logic [DW-1:0] pat(input logic [31:0] seed, input int k);
        logic [31:0] w;
        w = seed + 32'(k);
        return {16{w}};
    endfunction

    function automatic void model_wr(input int idx, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        for (int b = 0; b < DW/8; b++)
            if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // Avalon master write; data is replaced by POISON whenever ready is low so
    // any write taken while stalled corrupts the readback.
    task automatic wr_burst(input int addr, input int bc, input logic [DW/8-1:0] be,
                            input logic [31:0] seed, input int stall_at);
        int nb, k, n, sl;
        logic acc;
        bit stalled;
        nb = (bc == 0) ? 1 : bc;
        k = 0; n = 0; sl = 0; stalled = 0;
        amm_write = 1'b1;
        amm_address = AW'(addr);
        amm_burstcount = BW'(bc);
        amm_byteenable = be;
        while (k < nb) begin
            if (n >= 300) begin
                n_total++;
                $display("FAIL wr_timeout addr=%0h beats_done=%0d required=%0d", addr, k, nb);
                break;
            end
            acc = amm_ready;
            amm_writedata = (acc === 1'b1) ? pat(seed, k) : POISON;
            if (sl > 0) begin
                n_total++;
                if (acc !== 1'b0) $display("FAIL stall_ready got=%b required=0", acc);
                else n_pass++;
                sl--;
                if (sl == 0) i_stall = 1'b0;
            end else if (!stalled && stall_at >= 0 && k == stall_at) begin
                i_stall = 1'b1;
                stalled = 1;
                sl = 3;
            end
            @(negedge ddr_clk);
            n++;
            if (acc === 1'b1) begin
                model_wr((addr + k) % DEPTH, pat(seed, k), be);
                k++;
            end
        end
        amm_write = 1'b0;
        i_stall = 1'b0;
    endtask

    // Issues a read, checks every beat's data and arrival cycle and amm_ready
    // each cycle. abort_k >= 0 asserts reset right after beat abort_k arrives.
    task automatic rd_burst(input int addr, input int bc, input int abort_k);
        int n, nb, got, t;
        logic [DW-1:0] d;
        nb = (bc == 0) ? 1 : bc;
        n = 0;
        while (amm_ready !== 1'b1 && n < 300) begin
            @(negedge ddr_clk);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL rd_ready_timeout addr=%0h", addr);
            return;
        end
        amm_read = 1'b1;
        amm_address = AW'(addr);
        amm_burstcount = BW'(bc);
        for (int k = 0; k < nb; k++) begin
            exp_q.push_back(model[(addr + k) % DEPTH]);
            t_q.push_back(LAT + k);
        end
        got = 0;
        for (int i = 1; i <= LAT + nb + 1; i++) begin
            @(negedge ddr_clk);
            amm_read = 1'b0;
            n_total++;
            if (amm_ready !== ((i >= LAT + nb) ? 1'b1 : 1'b0))
                $display("FAIL rd_ready cyc=%0d got=%b required=%b", i, amm_ready, (i >= LAT + nb));
            else n_pass++;
            if (amm_readdatavalid === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rd_unexpected_beat cyc=%0d", i);
                end else begin
                    d = exp_q.pop_front();
                    t = t_q.pop_front();
                    if (amm_readdata !== d || i != t)
                        $display("FAIL rd_beat addr=%0h cyc=%0d required_cyc=%0d got=%h required=%h",
                                 addr, i, t, amm_readdata, d);
                    else n_pass++;
                end
                got++;
                if (abort_k >= 0 && got == abort_k + 1) begin
                    app_rst = 1'b1;
                    @(negedge ddr_clk);
                    n_total++;
                    if (amm_readdatavalid !== 1'b0 || amm_ready !== 1'b0)
                        $display("FAIL abort_flush valid=%b ready=%b required=0/0", amm_readdatavalid, amm_ready);
                    else n_pass++;
                    exp_q.delete();
                    t_q.delete();
                    return;
                end
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL rd_missing_beats got=%0d required=0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        t_q.delete();
    endtask

    task automatic reset_and_cal();
        int n;
        app_rst = 1'b1;
        repeat (3) @(negedge ddr_clk);
        app_rst = 1'b0;
        n = 0;
        while (local_cal_success !== 1'b1 && n < 200) begin
            @(negedge ddr_clk);
            n++;
        end
        n_total++;
        if (n != CALC) $display("FAIL cal_cycles got=%0d required=%0d", n, CALC);
        else n_pass++;
        n_total++;
        if (o_err !== 1'b0) $display("FAIL err_after_reset got=%b required=0", o_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        int vcnt;
        app_rst = 1'b1;
        repeat (3) @(negedge ddr_clk);
        n_total++;
        if ({local_cal_success, amm_ready, amm_readdatavalid, o_err} !== 4'b0 || amm_readdata !== '0)
            $display("FAIL reset_outputs got=%b rdata=%h required=0", {local_cal_success, amm_ready,
                     amm_readdatavalid, o_err}, amm_readdata);
        else n_pass++;
        amm_read = 1'b1;
        amm_address = AW'(32'h10);
        amm_burstcount = BW'(4);
        app_rst = 1'b0;
        vcnt = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge ddr_clk);
            if (i == 20) amm_read = 1'b0;
            if (amm_readdatavalid === 1'b1) vcnt++;
            if (i == CALC - 1) begin
                n_total++;
                if (local_cal_success !== 1'b0 || amm_ready !== 1'b0)
                    $display("FAIL cal_early cal=%b ready=%b required=0/0", local_cal_success, amm_ready);
                else n_pass++;
            end
            if (i == CALC) begin
                n_total++;
                if (local_cal_success !== 1'b1 || amm_ready !== 1'b1)
                    $display("FAIL cal_done cal=%b ready=%b required=1/1", local_cal_success, amm_ready);
                else n_pass++;
            end
        end
        n_total++;
        if (vcnt != 0 || o_err !== 1'b0)
            $display("FAIL cal_cmd_ignored valid_beats=%0d err=%b required=0/0", vcnt, o_err);
        else n_pass++;
    endtask

    task automatic test_write_burst();
        wr_burst(32'h10, 4, '1, 32'hA0A0_0000, -1);
        rd_burst(32'h10, 4, -1);
        n_total++;
        if (o_err !== 1'b0) $display("FAIL burst_err got=%b required=0", o_err);
        else n_pass++;
    endtask

    task automatic test_byteenable_wrap();
        wr_burst(32'h3FF, 2, '1, 32'h5555_0000, -1);
        wr_burst(32'h3FF, 1, 64'h1, 32'hFFFF_FFFF, -1);
        rd_burst(32'h3FF, 2, -1);
    endtask

    task automatic test_stall();
        wr_burst(32'h40, 6, '1, 32'h1234_0000, 2);
        rd_burst(32'h40, 6, -1);
    endtask

    task automatic test_proto_err();
        int n, vcnt;
        n = 0;
        while (amm_ready !== 1'b1 && n < 300) begin
            @(negedge ddr_clk);
            n++;
        end
        amm_write = 1'b1;
        amm_read = 1'b1;
        amm_address = AW'(32'h80);
        amm_burstcount = BW'(1);
        amm_byteenable = '1;
        amm_writedata = pat(32'hC0DE_0000, 0);
        @(negedge ddr_clk);
        amm_write = 1'b0;
        amm_read = 1'b0;
        model_wr(32'h80, pat(32'hC0DE_0000, 0), '1);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (amm_readdatavalid === 1'b1) vcnt++;
            @(negedge ddr_clk);
        end
        n_total++;
        if (vcnt != 0 || o_err !== 1'b1)
            $display("FAIL proto_err valid_beats=%0d err=%b required=0/1", vcnt, o_err);
        else n_pass++;
        rd_burst(32'h80, 1, -1);
        n_total++;
        if (o_err !== 1'b1) $display("FAIL err_sticky got=%b required=1", o_err);
        else n_pass++;
    endtask

    task automatic test_reset_rd_burst();
        wr_burst(32'h100, 8, '1, 32'h7700_0000, -1);
        rd_burst(32'h100, 8, 2);
        reset_and_cal();
        rd_burst(32'h100, 8, -1);
        rd_burst(32'h10, 4, -1);
    endtask

    task automatic test_bc_zero();
        wr_burst(32'h200, 0, '1, 32'h0BC0_0000, -1);
        n_total++;
        if (o_err !== 1'b1) $display("FAIL bc_zero_err got=%b required=1", o_err);
        else n_pass++;
        rd_burst(32'h200, 1, -1);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_byteenable_wrap();
        test_stall();
        test_proto_err();
        test_reset_rd_burst();
        test_bc_zero();
        repeat (2) @(negedge ddr_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
